// File: rtl/dcmac_0_axis_pkt_gen_ctrl.sv
// dcmac_0_axis_pkt_gen_ctrl
//   Packet control generator feeding the MTY-shift stage. Each beat it builds the
//   12-segment (12 x 16 B) control word: ena/sop/eop/err/mty and pkt_len per
//   segment, plus pkt_mty_idx/mty_sum so the shift stage can re-align a contiguous
//   byte stream onto segment-aligned packets.
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   i_start/i_stop   start a run (IDLE only) / finish the open packet, then idle
//   i_cfg_*          id, length mode, length range, packets per run (0 = continuous)
//   i_err_inject     set err on the next eop generated
//   i_rdy, o_vld     beat handshake; outputs hold while o_vld & !i_rdy
//   o_pkt_ctrl       {id,ena,pkt_len,sop,eop,err,mty,pkt_mty_idx,mty_sum}, MSB first
//   o_byte_cnt       stream bytes consumed by this beat
//   o_busy           generator not idle
//   o_pkt_cnt        eops accepted since the last i_start
module dcmac_0_axis_pkt_gen_ctrl #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 9600
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic [2:0]   i_cfg_id,
  input  logic [1:0]   i_cfg_len_mode,
  input  logic [15:0]  i_cfg_len_min,
  input  logic [15:0]  i_cfg_len_max,
  input  logic [31:0]  i_cfg_pkt_num,
  input  logic         i_err_inject,
  input  logic         i_rdy,
  output logic         o_vld,
  output logic [320:0] o_pkt_ctrl,
  output logic [7:0]   o_byte_cnt,
  output logic         o_busy,
  output logic [31:0]  o_pkt_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  function automatic logic [15:0] f_clamp(input logic [15:0] v, input logic [15:0] lo,
                                          input logic [15:0] hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  state_t        r_state;
  logic          r_vld;
  logic [320:0]  r_ctrl;
  logic [7:0]    r_byte_cnt;
  logic [2:0]    r_neop;
  logic [31:0]   r_pkt_cnt;
  logic [15:0]   r_lfsr;
  logic [15:0]   r_rem;
  logic [15:0]   r_cur_len;
  logic [15:0]   r_next_len;
  logic [31:0]   r_sop_cnt;
  logic          r_err_pend;
  logic          r_stop_req;
  logic [2:0]    r_id;
  logic [1:0]    r_mode;
  logic [15:0]   r_lo;
  logic [15:0]   r_hi;
  logic [31:0]   r_pkt_num;

  logic          w_adv, w_start, w_stop, w_build, w_sop_ok, w_limit;
  logic [15:0]   w_lo_in, w_hi_clamp, w_hi_in, w_lo, w_hi;
  logic [1:0]    w_mode;
  logic [2:0]    w_id;
  logic [31:0]   w_pkt_num;

  // Walk variables (evolve segment by segment inside the comb block)
  logic [15:0]        w_rem, w_len, w_nlen, w_lfsr;
  logic [31:0]        w_cnt;
  logic               w_pend;
  logic [1:0]         w_k;
  logic [5:0]         w_msum;
  logic [7:0]         w_tsum;
  logic [3:0]         w_nena;
  logic [2:0]         w_neop;
  logic [4:0]         w_mty_full;
  logic [11:0]        w_ena, w_sop, w_eop, w_err;
  logic [11:0][15:0]  w_plen;
  logic [11:0][3:0]   w_mty;
  logic [2:0][3:0]    w_idx;
  logic [2:0][5:0]    w_sum;
  logic [7:0]         w_byte;

  assign w_adv      = !r_vld || i_rdy;
  assign w_start    = (r_state == IDLE) && i_start;
  assign w_stop     = (r_state == RUN) && (i_stop || r_stop_req);
  assign w_lo_in    = f_clamp(i_cfg_len_min, 16'(MIN_LEN), 16'(MAX_LEN));
  assign w_hi_clamp = f_clamp(i_cfg_len_max, 16'(MIN_LEN), 16'(MAX_LEN));
  assign w_hi_in    = (w_hi_clamp < w_lo_in) ? w_lo_in : w_hi_clamp;
  // The first beat is built on the i_start edge, so config comes straight from the inputs then.
  assign w_lo       = w_start ? w_lo_in        : r_lo;
  assign w_hi       = w_start ? w_hi_in        : r_hi;
  assign w_mode     = w_start ? i_cfg_len_mode : r_mode;
  assign w_id       = w_start ? i_cfg_id       : r_id;
  assign w_pkt_num  = w_start ? i_cfg_pkt_num  : r_pkt_num;
  assign w_build    = w_start || (r_state == RUN) || ((r_state == DRAIN) && (r_rem != '0));
  assign w_sop_ok   = (w_start || (r_state == RUN)) && !w_stop;

  always_comb begin
    w_rem  = w_start ? '0 : r_rem;
    w_len  = r_cur_len;
    w_nlen = w_start ? w_lo_in : r_next_len;
    w_lfsr = r_lfsr;
    w_cnt  = w_start ? '0 : r_sop_cnt;
    w_pend = r_err_pend || i_err_inject;
    w_k    = '0;
    w_msum = '0;
    w_tsum = '0;
    w_nena = '0;
    w_neop = '0;
    w_mty_full = '0;
    w_ena  = '0;
    w_sop  = '0;
    w_eop  = '0;
    w_err  = '0;
    w_plen = '0;
    w_mty  = '0;
    w_idx  = {3{4'd12}};
    w_sum  = '0;
    for (int unsigned s = 0; s < 12; s++) begin
      if (w_build && (w_rem == '0) && w_sop_ok && ((w_pkt_num == '0) || (w_cnt < w_pkt_num))) begin
        case (w_mode)
          2'd1: begin
            w_len  = w_nlen;
            w_nlen = (w_nlen >= w_hi) ? w_lo : w_nlen + 16'd1;
          end
          2'd2: begin
            w_len  = f_clamp({2'b00, w_lfsr[13:0]}, w_lo, w_hi);
            w_lfsr = {w_lfsr[0] ^ w_lfsr[2] ^ w_lfsr[3] ^ w_lfsr[5], w_lfsr[15:1]};
          end
          default: w_len = w_lo;
        endcase
        w_rem    = w_len;
        w_sop[s] = 1'b1;
        w_cnt    = w_cnt + 32'd1;
      end
      if (w_rem != '0) begin
        w_ena[s]  = 1'b1;
        w_plen[s] = w_len;
        w_nena    = w_nena + 4'd1;
        if (w_rem <= 16'd16) begin
          w_mty_full = 5'd16 - w_rem[4:0];
          w_mty[s]   = w_mty_full[3:0];
          w_eop[s]   = 1'b1;
          w_err[s]   = w_pend;
          w_pend     = 1'b0;
          w_neop     = w_neop + 3'd1;
          w_tsum     = w_tsum + {4'b0000, w_mty[s]};
          // An eop in the last segment needs no shift, so it stays out of idx/sum.
          if (s < 11) begin
            w_msum       = w_msum + {2'b00, w_mty[s]};
            w_idx[w_k]   = 4'(s + 1);
            w_sum[w_k]   = w_msum;
            w_k          = w_k + 2'd1;
          end
          w_rem = '0;
        end else begin
          w_rem = w_rem - 16'd16;
        end
      end
    end
    for (int unsigned j = 0; j < 3; j++) begin
      if (j >= 32'(w_k)) w_sum[j] = w_msum;
    end
  end

  assign w_byte  = {w_nena, 4'b0000} - w_tsum;
  assign w_limit = (w_pkt_num != '0) && (w_cnt >= w_pkt_num);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_vld      <= 1'b0;
      r_ctrl     <= '0;
      r_byte_cnt <= '0;
      r_neop     <= '0;
      r_pkt_cnt  <= '0;
      r_lfsr     <= 16'hACE1;
      r_rem      <= '0;
      r_cur_len  <= '0;
      r_next_len <= '0;
      r_sop_cnt  <= '0;
      r_err_pend <= 1'b0;
      r_stop_req <= 1'b0;
      r_id       <= '0;
      r_mode     <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_pkt_num  <= '0;
    end else if (w_adv) begin
      r_stop_req <= 1'b0;
      if (w_start) begin
        r_id      <= i_cfg_id;
        r_mode    <= i_cfg_len_mode;
        r_lo      <= w_lo_in;
        r_hi      <= w_hi_in;
        r_pkt_num <= i_cfg_pkt_num;
        r_pkt_cnt <= '0;
      end else if (r_vld) begin
        r_pkt_cnt <= r_pkt_cnt + 32'(r_neop);
      end
      if (w_build) begin
        r_vld      <= |w_ena;
        r_ctrl     <= {w_id, w_ena, w_plen, w_sop, w_eop, w_err, w_mty, w_idx, w_sum};
        r_byte_cnt <= w_byte;
        r_neop     <= w_neop;
        r_rem      <= w_rem;
        r_cur_len  <= w_len;
        r_next_len <= w_nlen;
        r_lfsr     <= w_lfsr;
        r_sop_cnt  <= w_cnt;
        r_err_pend <= w_pend;
        r_state    <= ((r_state == DRAIN) || w_stop || w_limit) ? DRAIN : RUN;
      end else begin
        // DRAIN with nothing open: the final beat has just been accepted.
        r_vld      <= 1'b0;
        r_ctrl     <= '0;
        r_byte_cnt <= '0;
        r_neop     <= '0;
        r_err_pend <= r_err_pend || i_err_inject;
        if (r_state == DRAIN) r_state <= IDLE;
      end
    end else begin
      r_err_pend <= r_err_pend || i_err_inject;
      r_stop_req <= w_stop;
    end
  end

  assign o_vld      = r_vld;
  assign o_pkt_ctrl = r_ctrl;
  assign o_byte_cnt = r_byte_cnt;
  assign o_busy     = (r_state != IDLE);
  assign o_pkt_cnt  = r_pkt_cnt;

endmodule

// File: tb/tb_dcmac_0_axis_pkt_gen_ctrl.sv
// Directed bench for dcmac_0_axis_pkt_gen_ctrl with hand-computed expectations.
module tb_dcmac_0_axis_pkt_gen_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start, i_stop, i_err_inject, i_rdy;
  logic [2:0]   i_cfg_id;
  logic [1:0]   i_cfg_len_mode;
  logic [15:0]  i_cfg_len_min, i_cfg_len_max;
  logic [31:0]  i_cfg_pkt_num;
  logic         o_vld, o_busy;
  logic [320:0] o_pkt_ctrl;
  logic [7:0]   o_byte_cnt;
  logic [31:0]  o_pkt_cnt;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  dcmac_0_axis_pkt_gen_ctrl #(.MIN_LEN(64), .MAX_LEN(9600)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
    .i_cfg_id(i_cfg_id), .i_cfg_len_mode(i_cfg_len_mode),
    .i_cfg_len_min(i_cfg_len_min), .i_cfg_len_max(i_cfg_len_max),
    .i_cfg_pkt_num(i_cfg_pkt_num), .i_err_inject(i_err_inject), .i_rdy(i_rdy),
    .o_vld(o_vld), .o_pkt_ctrl(o_pkt_ctrl), .o_byte_cnt(o_byte_cnt),
    .o_busy(o_busy), .o_pkt_cnt(o_pkt_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] f_ena(input logic [320:0] c); return c[317:306]; endfunction
  function automatic logic [11:0] f_sop(input logic [320:0] c); return c[113:102]; endfunction
  function automatic logic [11:0] f_eop(input logic [320:0] c); return c[101:90];  endfunction
  function automatic logic [11:0] f_err(input logic [320:0] c); return c[89:78];   endfunction
  function automatic logic [11:0] f_idx(input logic [320:0] c); return c[29:18];   endfunction
  function automatic logic [17:0] f_sum(input logic [320:0] c); return c[17:0];    endfunction
  function automatic logic [2:0]  f_id (input logic [320:0] c); return c[320:318]; endfunction
  function automatic logic [15:0] f_len(input logic [320:0] c, input int s);
    return c[114 + 16*s +: 16];
  endfunction
  function automatic logic [3:0] f_mty(input logic [320:0] c, input int s);
    return c[30 + 4*s +: 4];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] mode, input logic [15:0] mn, input logic [15:0] mx,
                       input logic [31:0] num);
    i_cfg_len_mode = mode;
    i_cfg_len_min  = mn;
    i_cfg_len_max  = mx;
    i_cfg_pkt_num  = num;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic stop_pulse();
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
  endtask

  logic [320:0] saved;
  logic [7:0]   last_b;
  logic [11:0]  early;
  int           nb;

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_err_inject = 1'b0; i_rdy = 1'b1;
    i_cfg_id = 3'd5; i_cfg_len_mode = '0; i_cfg_len_min = 16'd64; i_cfg_len_max = 16'd64;
    i_cfg_pkt_num = '0;
    repeat (3) step();
    chk("rst_vld", 64'(o_vld), 64'd0);
    chk("rst_ctrl", 64'(|o_pkt_ctrl), 64'd0);
    chk("rst_bytes", 64'(o_byte_cnt), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_pktcnt", 64'(o_pkt_cnt), 64'd0);
    rst_n = 1'b1;
    step();

    // Fixed 64, three packets in one full beat
    start(2'd0, 16'd64, 16'd64, 32'd3);
    chk("t1_vld", 64'(o_vld), 64'd1);
    chk("t1_id", 64'(f_id(o_pkt_ctrl)), 64'd5);
    chk("t1_ena", 64'(f_ena(o_pkt_ctrl)), 64'hFFF);
    chk("t1_sop", 64'(f_sop(o_pkt_ctrl)), 64'h111);
    chk("t1_eop", 64'(f_eop(o_pkt_ctrl)), 64'h888);
    chk("t1_mty", 64'(o_pkt_ctrl[77:30]), 64'd0);
    chk("t1_idx", 64'(f_idx(o_pkt_ctrl)), 64'hC84);
    chk("t1_sum", 64'(f_sum(o_pkt_ctrl)), 64'd0);
    chk("t1_len7", 64'(f_len(o_pkt_ctrl, 7)), 64'd64);
    chk("t1_bytes", 64'(o_byte_cnt), 64'd192);
    chk("t1_pktcnt0", 64'(o_pkt_cnt), 64'd0);
    step();
    chk("t1_done_vld", 64'(o_vld), 64'd0);
    chk("t1_done_busy", 64'(o_busy), 64'd0);
    chk("t1_pktcnt", 64'(o_pkt_cnt), 64'd3);

    // Lengths below MIN_LEN clamp up to 64
    start(2'd0, 16'd10, 16'd20, 32'd3);
    chk("clamp_sop", 64'(f_sop(o_pkt_ctrl)), 64'h111);
    chk("clamp_len", 64'(f_len(o_pkt_ctrl, 0)), 64'd64);
    step();

    // Fixed 65, two packets
    start(2'd0, 16'd65, 16'd65, 32'd2);
    chk("t2_ena", 64'(f_ena(o_pkt_ctrl)), 64'h3FF);
    chk("t2_sop", 64'(f_sop(o_pkt_ctrl)), 64'h021);
    chk("t2_eop", 64'(f_eop(o_pkt_ctrl)), 64'h210);
    chk("t2_mty4", 64'(f_mty(o_pkt_ctrl, 4)), 64'd15);
    chk("t2_mty9", 64'(f_mty(o_pkt_ctrl, 9)), 64'd15);
    chk("t2_idx", 64'(f_idx(o_pkt_ctrl)), 64'hCA5);
    chk("t2_sum", 64'(f_sum(o_pkt_ctrl)), 64'({6'd30, 6'd30, 6'd15}));
    chk("t2_bytes", 64'(o_byte_cnt), 64'd130);
    step();
    chk("t2_next_vld", 64'(o_vld), 64'd0);
    chk("t2_pktcnt", 64'(o_pkt_cnt), 64'd2);

    // Incrementing 64..66, continuous, stopped mid-packet
    start(2'd1, 16'd64, 16'd66, 32'd0);
    chk("t3b0_sop", 64'(f_sop(o_pkt_ctrl)), 64'h211);
    chk("t3b0_eop", 64'(f_eop(o_pkt_ctrl)), 64'h108);
    chk("t3b0_len4", 64'(f_len(o_pkt_ctrl, 4)), 64'd65);
    chk("t3b0_len9", 64'(f_len(o_pkt_ctrl, 9)), 64'd66);
    chk("t3b0_idx", 64'(f_idx(o_pkt_ctrl)), 64'hC94);
    chk("t3b0_sum", 64'(f_sum(o_pkt_ctrl)), 64'({6'd15, 6'd15, 6'd0}));
    chk("t3b0_bytes", 64'(o_byte_cnt), 64'd177);
    step();
    chk("t3b1_sop", 64'(f_sop(o_pkt_ctrl)), 64'h844);
    chk("t3b1_eop", 64'(f_eop(o_pkt_ctrl)), 64'h422);
    chk("t3b1_len0", 64'(f_len(o_pkt_ctrl, 0)), 64'd66);
    chk("t3b1_len2", 64'(f_len(o_pkt_ctrl, 2)), 64'd64);
    chk("t3b1_len6", 64'(f_len(o_pkt_ctrl, 6)), 64'd65);
    chk("t3b1_len11", 64'(f_len(o_pkt_ctrl, 11)), 64'd66);
    chk("t3b1_idx", 64'(f_idx(o_pkt_ctrl)), 64'hB62);
    chk("t3b1_sum", 64'(f_sum(o_pkt_ctrl)), 64'({6'd29, 6'd14, 6'd14}));
    chk("t3b1_bytes", 64'(o_byte_cnt), 64'd163);
    stop_pulse();
    chk("t3b2_ena", 64'(f_ena(o_pkt_ctrl)), 64'h00F);
    chk("t3b2_sop", 64'(f_sop(o_pkt_ctrl)), 64'h000);
    chk("t3b2_eop", 64'(f_eop(o_pkt_ctrl)), 64'h008);
    chk("t3b2_mty3", 64'(f_mty(o_pkt_ctrl, 3)), 64'd14);
    chk("t3b2_idx", 64'(f_idx(o_pkt_ctrl)), 64'hCC4);
    chk("t3b2_bytes", 64'(o_byte_cnt), 64'd50);
    chk("t3b2_busy", 64'(o_busy), 64'd1);
    step();
    chk("t3_idle_vld", 64'(o_vld), 64'd0);
    chk("t3_idle_busy", 64'(o_busy), 64'd0);
    chk("t3_pktcnt", 64'(o_pkt_cnt), 64'd6);

    // i_stop while idle has no effect
    stop_pulse();
    chk("idle_stop_busy", 64'(o_busy), 64'd0);

    // Backpressure: five stalled cycles, then the sequence resumes unchanged
    start(2'd1, 16'd64, 16'd66, 32'd0);
    saved = o_pkt_ctrl;
    chk("t4_b0_sop", 64'(f_sop(o_pkt_ctrl)), 64'h211);
    i_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_vld", 64'(o_vld), 64'd1);
      chk("t4_hold_ctrl", 64'(o_pkt_ctrl == saved), 64'd1);
      chk("t4_hold_cnt", 64'(o_pkt_cnt), 64'd0);
    end
    i_rdy = 1'b1;
    step();
    chk("t4_b1_sop", 64'(f_sop(o_pkt_ctrl)), 64'h844);
    chk("t4_b1_len2", 64'(f_len(o_pkt_ctrl, 2)), 64'd64);
    chk("t4_b1_len11", 64'(f_len(o_pkt_ctrl, 11)), 64'd66);
    chk("t4_b1_mty1", 64'(f_mty(o_pkt_ctrl, 1)), 64'd14);
    chk("t4_pktcnt", 64'(o_pkt_cnt), 64'd2);
    stop_pulse();
    chk("t4_b2_eop", 64'(f_eop(o_pkt_ctrl)), 64'h008);
    step();
    chk("t4_idle", 64'(o_busy), 64'd0);

    // Error injection on a 9600-byte packet spanning 50 beats
    i_err_inject = 1'b1;
    start(2'd0, 16'd9600, 16'd9600, 32'd1);
    i_err_inject = 1'b0;
    chk("t5_sop", 64'(f_sop(o_pkt_ctrl)), 64'h001);
    chk("t5_len", 64'(f_len(o_pkt_ctrl, 5)), 64'd9600);
    nb = 0;
    early = '0;
    saved = '0;
    last_b = '0;
    while (o_vld === 1'b1 && nb < 60) begin
      nb++;
      saved = o_pkt_ctrl;
      last_b = o_byte_cnt;
      if (nb < 50) early = early | f_err(o_pkt_ctrl) | f_eop(o_pkt_ctrl);
      step();
    end
    chk("t5_beats", 64'(nb), 64'd50);
    chk("t5_early_err_eop", 64'(early), 64'd0);
    chk("t5_last_eop", 64'(f_eop(saved)), 64'h800);
    chk("t5_last_err", 64'(f_err(saved)), 64'h800);
    chk("t5_last_idx", 64'(f_idx(saved)), 64'hCCC);
    chk("t5_last_bytes", 64'(last_b), 64'd192);
    chk("t5_pktcnt", 64'(o_pkt_cnt), 64'd1);
    chk("t5_busy", 64'(o_busy), 64'd0);

    // PRBS from the reset seed, then an asynchronous reset mid-run
    start(2'd2, 16'd64, 16'd9600, 32'd0);
    chk("t6_sop", 64'(f_sop(o_pkt_ctrl)), 64'h001);
    chk("t6_prbs_len", 64'(f_len(o_pkt_ctrl, 0)), 64'd9600);
    step();
    chk("t6_run_busy", 64'(o_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", 64'(o_vld), 64'd0);
    chk("t6_rst_ctrl", 64'(|o_pkt_ctrl), 64'd0);
    chk("t6_rst_bytes", 64'(o_byte_cnt), 64'd0);
    chk("t6_rst_busy", 64'(o_busy), 64'd0);
    rst_n = 1'b1;
    step();
    start(2'd0, 16'd64, 16'd64, 32'd0);
    chk("t6_re_vld", 64'(o_vld), 64'd1);
    chk("t6_re_sop", 64'(f_sop(o_pkt_ctrl)), 64'h111);
    chk("t6_re_cnt0", 64'(o_pkt_cnt), 64'd0);
    step();
    chk("t6_re_cnt", 64'(o_pkt_cnt), 64'd3);
    rst_n = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
